// File: rtl/fadd_issue_ctrl_pkg.sv
// ============================================================================
// fadd_issue_ctrl_pkg : shared FPU constants for the adder issue controller
// Rev 1.0
// ============================================================================
`default_nettype none

package fadd_issue_ctrl_pkg;

   localparam int c_FP_W        = 32;
   localparam int c_FADD_DEPTH  = 2;
   localparam int c_INFLIGHT_W  = $clog2(c_FADD_DEPTH + 1);

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RDN = 2'b10,
      RM_RUP = 2'b11
   } fp_rm_e;

   function automatic logic [c_INFLIGHT_W-1:0] count_valid(input logic [c_FADD_DEPTH-1:0] v);
      logic [c_INFLIGHT_W-1:0] n;
      n = '0;
      for (int i = 0; i < c_FADD_DEPTH; i++) begin
         n = n + c_INFLIGHT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fadd_issue_ctrl_tag_stage.sv
// ============================================================================
// fadd_tag_stage : one enabled, flushable valid+tag shadow register
// Rev 1.0
// ============================================================================
`default_nettype none

module fadd_tag_stage #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             i_en,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag
);

   logic             r_valid;
   logic [TAG_W-1:0] r_tag;

   // Flush only clears the valid bit; the tag is don't-care once invalid.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_tag   <= i_tag;
      end
   end

   assign o_valid = r_valid;
   assign o_tag   = r_tag;

endmodule

`default_nettype wire

// File: rtl/fadd_issue_ctrl.sv
// ============================================================================
// fadd_issue_ctrl : issue/retire controller in front of the pipelined FP adder
// Rev 1.0
// ============================================================================
`default_nettype none

module fadd_issue_ctrl
   import fadd_issue_ctrl_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [c_FP_W-1:0]       in_a,
   input  logic [c_FP_W-1:0]       in_b,
   input  logic                    in_sub,
   input  logic [1:0]              in_rm,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic                    flush,
   output logic [c_FP_W-1:0]       fa,
   output logic [c_FP_W-1:0]       fb,
   output logic                    fsub,
   output logic [1:0]              frm,
   output logic                    fe,
   input  logic [c_FP_W-1:0]       fs,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [c_FP_W-1:0]       out_data,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    busy,
   output logic [c_INFLIGHT_W-1:0] inflight,
   output logic [CNT_W-1:0]        done_cnt
);

   logic                    w_accept;
   logic                    w_done;
   logic                    w_last_v;
   logic [c_FADD_DEPTH-1:0] w_stage_v;
   logic [TAG_W-1:0]        w_stage_tag [c_FADD_DEPTH];
   logic [CNT_W-1:0]        r_done_cnt;

   assign fa   = in_a;
   assign fb   = in_b;
   assign fsub = in_sub;
   assign frm  = in_rm;

   // A result waiting on the consumer freezes the whole adder; flush always clocks it.
   assign w_last_v = w_stage_v[c_FADD_DEPTH-1];
   assign fe       = flush | ~(w_last_v & ~out_ready);
   assign in_ready = fe & ~flush;
   assign w_accept = in_valid & in_ready;

   generate
      for (genvar gi = 0; gi < c_FADD_DEPTH; gi++) begin : g_stage
         logic             w_in_v;
         logic [TAG_W-1:0] w_in_tag;
         if (gi == 0) begin : g_head
            assign w_in_v   = w_accept;
            assign w_in_tag = in_tag;
         end else begin : g_chain
            assign w_in_v   = w_stage_v[gi-1];
            assign w_in_tag = w_stage_tag[gi-1];
         end
         fadd_tag_stage #(
            .TAG_W (TAG_W)
         ) u_stage (
            .clk     (clk),
            .clrn    (clrn),
            .i_en    (fe),
            .i_flush (flush),
            .i_valid (w_in_v),
            .i_tag   (w_in_tag),
            .o_valid (w_stage_v[gi]),
            .o_tag   (w_stage_tag[gi])
         );
      end
   endgenerate

   assign out_valid = w_last_v & ~flush;
   assign out_data  = fs;
   assign out_tag   = w_stage_tag[c_FADD_DEPTH-1];
   assign w_done    = out_valid & out_ready;

   assign busy     = |w_stage_v;
   assign inflight = count_valid(w_stage_v);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_done_cnt <= '0;
      end else if (w_done) begin
         r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
   end

   assign done_cnt = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fadd_issue_ctrl.sv
// ============================================================================
// tb_fadd_issue_ctrl : scoreboard bench for fadd_issue_ctrl with an adder model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fadd_issue_ctrl;

   logic        clk = 1'b0;
   logic        clrn;
   logic        in_valid, in_ready;
   logic [31:0] in_a, in_b;
   logic        in_sub;
   logic [1:0]  in_rm;
   logic [4:0]  in_tag;
   logic        flush;
   logic [31:0] fa, fb, fs;
   logic        fsub, fe;
   logic [1:0]  frm;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        busy;
   logic [1:0]  inflight;
   logic [15:0] done_cnt;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  t;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fadd_issue_ctrl #(.TAG_W(5), .CNT_W(16)) dut (
      .clk(clk), .clrn(clrn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm), .in_tag(in_tag),
      .flush(flush),
      .fa(fa), .fb(fb), .fsub(fsub), .frm(frm), .fe(fe), .fs(fs),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .busy(busy), .inflight(inflight), .done_cnt(done_cnt)
   );

   // Two-register-stage adder model over a small table of known sums.
   function automatic logic [31:0] fp_lut(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] r;
      r = 32'h7FC00000;
      case ({s, a, b})
         {1'b0, 32'h3F800000, 32'h40000000}: r = 32'h40400000;
         {1'b0, 32'h3F800000, 32'h3F800000}: r = 32'h40000000;
         {1'b1, 32'h40000000, 32'h3F800000}: r = 32'h3F800000;
         {1'b0, 32'h40800000, 32'h40800000}: r = 32'h41000000;
         {1'b0, 32'h40400000, 32'h3F800000}: r = 32'h40800000;
         {1'b0, 32'h40A00000, 32'h40A00000}: r = 32'h41200000;
         default: r = 32'h7FC00000;
      endcase
      return r;
   endfunction

   logic [31:0] r_s1, r_s2;
   always @(posedge clk) begin
      if (fe) begin
         r_s1 <= fp_lut(fa, fb, fsub);
         r_s2 <= r_s1;
      end
   end
   assign fs = r_s2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every result handshake pops the oldest expectation.
   always @(negedge clk) begin
      if (clrn && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data %h tag %0d with empty scoreboard", out_data, out_tag);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("result_data", out_data, e.d);
            chk("result_tag", 32'(out_tag), 32'(e.t));
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [4:0] tag, input logic [31:0] exp_d, input bit push);
      int n;
      exp_t e;
      n = 0;
      in_a = a; in_b = b; in_sub = s; in_rm = 2'b00; in_tag = tag; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready %b required 1 for tag %0d", in_ready, tag);
      end else if (push) begin
         e.d = exp_d;
         e.t = tag;
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #900000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      clrn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
      in_rm = 2'b00; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_fe", 32'(fe), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      clrn = 1'b1;
      @(posedge clk); #1;

      // Single op: 1.0 + 2.0
      in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b1; in_rm = 2'b11; #1;
      chk("fa_copy", fa, 32'h3F800000);
      chk("fb_copy", fb, 32'h40000000);
      chk("fsub_copy", 32'(fsub), 32'd1);
      chk("frm_copy", 32'(frm), 32'd3);
      issue(32'h3F800000, 32'h40000000, 1'b0, 5'd5, 32'h40400000, 1);
      chk("t1_inflight", 32'(inflight), 32'd1);
      chk("t1_out_valid_early", 32'(out_valid), 32'd0);
      idle(1);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_tag", 32'(out_tag), 32'd5);
      idle(1);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);

      // Back-to-back: 1+1, 2-1, 4+4
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd1, 32'h40000000, 1);
      chk("t2_in_ready1", 32'(in_ready), 32'd1);
      issue(32'h40000000, 32'h3F800000, 1'b1, 5'd2, 32'h3F800000, 1);
      chk("t2_in_ready2", 32'(in_ready), 32'd1);
      chk("t2_inflight", 32'(inflight), 32'd2);
      issue(32'h40800000, 32'h40800000, 1'b0, 5'd3, 32'h41000000, 1);
      chk("t2_tag2", 32'(out_tag), 32'd2);
      idle(1);
      chk("t2_valid3", 32'(out_valid), 32'd1);
      chk("t2_tag3", 32'(out_tag), 32'd3);
      idle(1);
      chk("t2_drained", 32'(out_valid), 32'd0);
      chk("t2_done_cnt", 32'(done_cnt), 32'd4);

      // Stall with two ops in flight
      out_ready = 1'b0;
      issue(32'h40400000, 32'h3F800000, 1'b0, 5'd7, 32'h40800000, 1);
      issue(32'h40A00000, 32'h40A00000, 1'b0, 5'd8, 32'h41200000, 1);
      for (int i = 0; i < 3; i++) begin
         chk("t3_fe", 32'(fe), 32'd0);
         chk("t3_in_ready", 32'(in_ready), 32'd0);
         chk("t3_data", out_data, 32'h40800000);
         chk("t3_tag", 32'(out_tag), 32'd7);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t3_next_valid", 32'(out_valid), 32'd1);
      chk("t3_next_tag", 32'(out_tag), 32'd8);
      chk("t3_next_data", out_data, 32'h41200000);
      idle(2);
      chk("t3_done_cnt", 32'(done_cnt), 32'd6);

      // Flush with two ops in flight
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd9, 32'h40000000, 0);
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd10, 32'h40000000, 0);
      flush = 1'b1; #1;
      chk("t4_out_valid_flush", 32'(out_valid), 32'd0);
      chk("t4_in_ready_flush", 32'(in_ready), 32'd0);
      chk("t4_fe_flush", 32'(fe), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; #1;
      chk("t4_inflight", 32'(inflight), 32'd0);
      chk("t4_out_valid", 32'(out_valid), 32'd0);
      chk("t4_done_cnt", 32'(done_cnt), 32'd6);
      issue(32'h3F800000, 32'h40000000, 1'b0, 5'd11, 32'h40400000, 1);
      idle(2);
      chk("t4_done_after", 32'(done_cnt), 32'd7);

      // Asynchronous reset mid-operation
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd4, 32'h40000000, 0);
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd6, 32'h40000000, 0);
      chk("t5_inflight_pre", 32'(inflight), 32'd2);
      clrn = 1'b0; #1;
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done_cnt", 32'(done_cnt), 32'd0);
      chk("t5_inflight", 32'(inflight), 32'd0);
      @(posedge clk); #1;
      clrn = 1'b1;
      @(posedge clk); #1;
      issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd12, 32'h40000000, 1);
      idle(1);
      chk("t5_new_valid", 32'(out_valid), 32'd1);
      chk("t5_new_data", out_data, 32'h40000000);
      idle(1);
      chk("t5_new_done", 32'(done_cnt), 32'd1);

      // Counter wrap
      for (int i = 0; i < 65534; i++) begin
         issue(32'h3F800000, 32'h3F800000, 1'b0, 5'(i), 32'h40000000, 1);
      end
      idle(3);
      chk("t6_done_max", 32'(done_cnt), 32'h0000FFFF);
      issue(32'h40800000, 32'h40800000, 1'b0, 5'd31, 32'h41000000, 1);
      idle(3);
      chk("t6_done_wrap", 32'(done_cnt), 32'h00000000);

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
